// File: rtl/line_fill_server_if.sv
// Cache-side bus of the line fill server: request handshake, beat stream and store loader.
// The master side is the cache or test driver, and the slave side is the server.
interface line_fill_server_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [31:0] resp_addr;
    logic        resp_last;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    modport master (
        output req_valid, req_addr, resp_stall, load_en, load_addr, load_data,
        input  req_ready, resp_valid, resp_data, resp_addr, resp_last
    );

    modport slave (
        input  req_valid, req_addr, resp_stall, load_en, load_addr, load_data,
        output req_ready, resp_valid, resp_data, resp_addr, resp_last
    );
endinterface

// File: rtl/line_fill_server.sv
// Serves 8-word line fills critical-word-first from a word-addressed backing store.
// There is no request queueing. Beats hold while the cache stalls.
module line_fill_server #(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 4
) (
    input  logic                clk,
    input  logic                reset,
    line_fill_server_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [26:0] r_line;
    logic [2:0]  r_off;
    logic [2:0]  r_beat;
    logic        r_req_ready;
    logic        r_valid;
    logic        r_last;
    logic [31:0] r_data;
    logic [31:0] r_addr;

    logic [2:0]        w_fetch_off;
    logic [31:0]       w_fetch_addr;
    logic [ADDR_W-1:0] w_fetch_idx;
    logic [31:0]       w_ld_word;
    logic [ADDR_W-1:0] w_ld_idx;

    // In WAIT the first beat comes from the start offset. In BURST the next beat is fetched one word ahead.
    assign w_fetch_off  = (r_state == S_BURST) ? r_off + 3'd1 : r_off;
    assign w_fetch_addr = {r_line, w_fetch_off, 2'b00};
    assign w_fetch_idx  = ADDR_W'({r_line, w_fetch_off});
    assign w_ld_word    = bus.load_addr >> 2;
    assign w_ld_idx     = ADDR_W'(w_ld_word);

    // Reset does not touch the store. A same-edge load/fetch collision returns the old word.
    always_ff @(posedge clk) begin
        if (bus.load_en)
            mem[w_ld_idx] <= bus.load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_line      <= '0;
            r_off       <= '0;
            r_beat      <= '0;
            r_req_ready <= 1'b1;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_data      <= '0;
            r_addr      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_line      <= bus.req_addr[31:5];
                        r_off       <= bus.req_addr[4:2];
                        r_cnt       <= 4'(LATENCY - 1);
                        r_req_ready <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_BURST;
                        r_beat  <= 3'd0;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_data  <= mem[w_fetch_idx];
                        r_addr  <= w_fetch_addr;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_BURST: begin
                    if (!bus.resp_stall) begin
                        if (r_beat == 3'd7) begin
                            r_state     <= S_IDLE;
                            r_req_ready <= 1'b1;
                            r_valid     <= 1'b0;
                            r_last      <= 1'b0;
                            r_data      <= '0;
                            r_addr      <= '0;
                        end else begin
                            r_beat <= r_beat + 3'd1;
                            r_off  <= w_fetch_off;
                            r_last <= (r_beat == 3'd6);
                            r_data <= mem[w_fetch_idx];
                            r_addr <= w_fetch_addr;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_valid;
    assign bus.resp_last  = r_last;
    assign bus.resp_data  = r_data;
    assign bus.resp_addr  = r_addr;
endmodule

// File: tb/tb_line_fill_server.sv
// Directed and random line fills checked against a word-array model of the backing store.
// The bench also covers stalls, a same-edge load collision, reset in mid-burst and back-to-back requests.
module tb_line_fill_server;
    localparam int ADDR_W  = 14;
    localparam int LATENCY = 4;

    logic clk;
    logic reset;
    line_fill_server_if bus ();

    line_fill_server #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] mm [0:(1<<ADDR_W)-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input int idx, input logic [31:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = 32'(idx) << 2;
        bus.load_data = d;
        @(negedge clk);
        bus.load_en   = 1'b0;
        mm[idx]       = d;
    endtask

    // The task enters and leaves on a negedge. Setting col_beat to k loads col_data into word col_idx on the edge that fetches beat k.
    // abort_beat resets the DUT while that beat is on the bus. stall_beat is held for 3 edges.
    task automatic fill(input logic [31:0] a, input bit chain, input logic [31:0] nxt,
                        input int stall_pct, input int stall_beat, input int col_beat,
                        input int col_idx, input logic [31:0] col_data, input int abort_beat);
        logic [31:0] exp [8];
        logic [2:0]  off;
        int k, cyc, nst;
        bit st;
        for (int i = 0; i < 8; i++) begin
            off    = 3'(a[4:2] + 3'(i));
            exp[i] = mm[{a[15:5], off}];
        end
        cyc = 0;
        while (!bus.req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        @(negedge clk);
        bus.req_valid = chain;
        bus.req_addr  = nxt;
        chk("busy_after_accept", 32'(bus.req_ready), 32'd0);
        chk("no_valid_at_accept", 32'(bus.resp_valid), 32'd0);
        for (int t = 1; t < LATENCY; t++) begin
            @(negedge clk);
            chk("no_valid_in_wait", 32'(bus.resp_valid), 32'd0);
        end
        @(negedge clk);
        k   = 0;
        nst = 0;
        while (k < 8) begin
            chk("beat_valid", 32'(bus.resp_valid), 32'd1);
            chk("beat_data",  bus.resp_data, exp[k]);
            chk("beat_addr",  bus.resp_addr, {a[31:5], 3'(a[4:2] + 3'(k)), 2'b00});
            chk("beat_last",  32'(bus.resp_last), 32'(k == 7));
            chk("beat_busy",  32'(bus.req_ready), 32'd0);
            if (abort_beat == k) begin
                #2 reset = 1'b1;
                #1;
                chk("abort_valid", 32'(bus.resp_valid), 32'd0);
                chk("abort_ready", 32'(bus.req_ready), 32'd1);
                chk("abort_data",  bus.resp_data, 32'd0);
                bus.req_valid  = 1'b0;
                bus.resp_stall = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                chk("abort_quiet", 32'(bus.resp_valid), 32'd0);
                return;
            end
            st = ($urandom_range(99) < 32'(stall_pct));
            if (k == stall_beat && nst < 3) begin
                st = 1'b1;
                nst++;
            end
            if (col_beat == k + 1) begin
                st            = 1'b0;
                bus.load_en   = 1'b1;
                bus.load_addr = 32'(col_idx) << 2;
                bus.load_data = col_data;
            end
            bus.resp_stall = st;
            @(negedge clk);
            if (bus.load_en) begin
                bus.load_en  = 1'b0;
                mm[col_idx]  = col_data;
            end
            if (!st) k++;
        end
        bus.resp_stall = 1'b0;
        chk("end_valid", 32'(bus.resp_valid), 32'd0);
        chk("end_last",  32'(bus.resp_last), 32'd0);
        chk("end_ready", 32'(bus.req_ready), 32'd1);
        chk("end_data",  bus.resp_data, 32'd0);
        chk("end_addr",  bus.resp_addr, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_stall = 1'b0;
        bus.load_en    = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        reset          = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mm[i] = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_last",  32'(bus.resp_last), 32'd0);
        chk("rst_data",  bus.resp_data, 32'd0);
        chk("rst_addr",  bus.resp_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) load_word(i, 32'h1000 + 32'(i));
        for (int i = 16; i < 256; i++) load_word(i, $urandom);

        // aligned, wrapped, then a 3-edge stall on beat 2
        fill(32'h20, 0, 0, 0, -1, -1, 0, 0, -1);
        fill(32'h3C, 0, 0, 0, -1, -1, 0, 0, -1);
        fill(32'h20, 0, 0, 0,  2, -1, 0, 0, -1);
        // reset while beat 3 is on the bus, then a clean refill
        fill(32'h20, 0, 0, 0, -1, -1, 0, 0,  3);
        fill(32'h20, 0, 0, 0, -1, -1, 0, 0, -1);
        // load to 0x30 on the edge that fetches beat 4
        fill(32'h20, 0, 0, 0, -1,  4, 12, 32'hDEADBEEF, -1);
        fill(32'h20, 0, 0, 0, -1, -1, 0, 0, -1);
        // back-to-back with req_valid held high across the first fill
        fill(32'h20, 1, 32'h40, 0, -1, -1, 0, 0, -1);
        fill(32'h40, 0, 0, 0, -1, -1, 0, 0, -1);

        // random lines, with aliasing upper address bits and random stalls
        for (int n = 0; n < 12; n++) begin
            ra = {16'($urandom), 6'd0, 8'($urandom_range(0, 255)), 2'b00};
            fill(ra, 0, 0, 35, -1, -1, 0, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
